fib_sequencer: RTL and testbench
================================

FIB_SEQUENCER -- requirements
Module: fib_sequencer

Interface
REQ-001 SHALL have parameter NBYTES, default 2: operand/result width in bytes (valid range 1..8).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request a computation; sampled only in IDLE.
REQ-005 SHALL have port n, input, 8: Fibonacci index; sampled with start.
REQ-006 SHALL have port busy, output, 1: high in ADD state.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when fib/overflow are valid.
REQ-008 SHALL have port fib, output, 8*NBYTES: F(n), registered; held until the next done.
REQ-009 SHALL have port overflow, output, 1: F(n) exceeded 2^(8*NBYTES)-1; held with fib.
REQ-010 SHALL have ports alu_left and alu_right, output, 8 each: byte operands to the external 8-bit ALU.
REQ-011 SHALL have port alu_carry_in, output, 1: carry into the ALU.
REQ-012 SHALL have port alu_op, output, 2: ALU opcode (0 ADC, 1 SBB, 2 AND, 3 OR).
REQ-013 SHALL have ports alu_result, input, 8, and alu_carry_out, input, 1: combinational ALU response in the same cycle.

Function
REQ-014 SHALL implement states IDLE, ADD and DONE.
REQ-015 In IDLE with start=1: SHALL load a=0, b=1, remaining=n, byte index=0, carry=0; next state ADD if n!=0, else DONE.
REQ-016 In ADD: SHALL drive alu_op=0, alu_left=a[idx], alu_right=b[idx], alu_carry_in=carry (0 at idx 0); SHALL write b[idx]<=alu_result, a[idx]<=b[idx], carry<=alu_carry_out.
REQ-017 At idx=NBYTES-1: idx SHALL wrap to 0 and remaining SHALL decrement; on reaching 0, next state DONE.
REQ-018 Overflow tracking: a top-byte carry out SHALL set sticky b_ovf; at each iteration end a_ovf SHALL take the previous b_ovf. Reported overflow SHALL be a_ovf, so overflow of F(n+1) alone is not reported.
REQ-019 In DONE: SHALL register fib=a and overflow=a_ovf, pulse done for exactly one cycle, and return to IDLE.
REQ-020 Latency: done SHALL rise exactly n*NBYTES+1 cycles after the cycle in which start is accepted.
REQ-021 Outside ADD: alu_left, alu_right, alu_carry_in and alu_op SHALL be 0.
REQ-022 start in ADD or DONE SHALL be ignored; a start held high SHALL be accepted on the first IDLE cycle.

Reset
REQ-023 reset SHALL force IDLE and clear busy, done, fib, overflow, all internal registers and all ALU drive outputs to 0.
REQ-024 reset mid-computation SHALL abort with no done pulse; reset has priority over start.

Configuration
REQ-025 With FIB_OVF_STOP_EN defined: when a_ovf sets, the FSM SHALL go directly to DONE, reporting fib=all-ones and overflow=1.
REQ-026 Without FIB_OVF_STOP_EN: all n iterations SHALL run, fib=F(n) mod 2^(8*NBYTES), overflow=1, and latency per REQ-020.

Structure
REQ-027 Package fib_pkg SHALL hold the state enum typedef and the ALU opcode constants OP_ADC=0, OP_SBB=1, OP_AND=2, OP_OR=3.
REQ-028 SHALL contain no sub-module; the ALU SHALL be instantiated by the parent, and the bench SHALL connect a real ALU.

Verification (NBYTES=2)
REQ-029 start, n=0 -> done 1 cycle later, fib=0x0000, overflow=0.
REQ-030 n=10 -> done 21 cycles after start, fib=0x0037; n=14 -> fib=0x0179 (byte carry exercised).
REQ-031 n=24 -> fib=0xB520, overflow=0 (F(25) overflow not reported).
REQ-032 n=25 -> without macro fib=0x2511, overflow=1, latency 51; with FIB_OVF_STOP_EN fib=0xFFFF, overflow=1, done before cycle 51.
REQ-033 n=10, start pulsed again at cycle 5, then reset at cycle 8 -> second start ignored, no done, all outputs 0, next start behaves normally.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: FSM state encoding,
// external ALU opcodes and a helper for sizing the byte index.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } fib_state_t;

    localparam logic [1:0] OP_ADC = 2'd0;
    localparam logic [1:0] OP_SBB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/fib_sequencer_if.sv
// Command/result and byte-ALU signals of the Fibonacci sequencer.
// The master modport is the parent (issues start, hosts the ALU); the slave is the sequencer.
interface fib_sequencer_if #(
    parameter int NBYTES = 2
);
    logic                  start;
    logic [7:0]            n;
    logic                  busy;
    logic                  done;
    logic [8*NBYTES-1:0]   fib;
    logic                  overflow;
    logic [7:0]            alu_left;
    logic [7:0]            alu_right;
    logic                  alu_carry_in;
    logic [1:0]            alu_op;
    logic [7:0]            alu_result;
    logic                  alu_carry_out;

    modport master (
        output start, n, alu_result, alu_carry_out,
        input  busy, done, fib, overflow, alu_left, alu_right, alu_carry_in, alu_op
    );

    modport slave (
        input  start, n, alu_result, alu_carry_out,
        output busy, done, fib, overflow, alu_left, alu_right, alu_carry_in, alu_op
    );
endinterface

// File: rtl/fib_alu.sv
// Combinational 8-bit ALU (ADC, SBB, AND, OR) that the parent connects to the
// sequencer's byte-wide operand/result ports.
module fib_alu
    import fib_pkg::*;
(
    input  logic [1:0] i_op,
    input  logic [7:0] i_left,
    input  logic [7:0] i_right,
    input  logic       i_carry,
    output logic [7:0] o_result,
    output logic       o_carry
);
    logic [8:0] w_sum;
    logic [8:0] w_diff;

    // For SBB the carry output is the borrow out of the subtraction
    always_comb begin
        w_sum    = {1'b0, i_left} + {1'b0, i_right} + {8'd0, i_carry};
        w_diff   = {1'b0, i_left} - {1'b0, i_right} - {8'd0, i_carry};
        o_result = 8'd0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADC: begin
                o_result = w_sum[7:0];
                o_carry  = w_sum[8];
            end
            OP_SBB: begin
                o_result = w_diff[7:0];
                o_carry  = w_diff[8];
            end
            OP_AND: o_result = i_left & i_right;
            OP_OR:  o_result = i_left | i_right;
            default: o_result = 8'd0;
        endcase
    end
endmodule

// File: rtl/fib_sequencer.sv
// Computes F(n) one byte per cycle through an external 8-bit ALU.
// Optional FIB_OVF_STOP_EN: stop as soon as the result is known to overflow and report all-ones.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int NBYTES = 2
)(
    input  logic           clk,
    input  logic           reset,
    fib_sequencer_if.slave bus
);
    localparam int IDXW = idx_width(NBYTES);
    localparam int W    = 8 * NBYTES;

    fib_state_t              r_state, w_next;
    logic [NBYTES-1:0][7:0]  r_a, r_b, w_a, w_b;
    logic [7:0]              r_rem, w_rem;
    logic [IDXW-1:0]         r_idx, w_idx;
    logic                    r_carry, w_carry;
    logic                    r_a_ovf, w_a_ovf;
    logic                    r_b_ovf, w_b_ovf;
    logic [W-1:0]            r_fib, w_fib;
    logic                    r_ovf, w_ovf;
    logic                    w_last_byte;
`ifdef FIB_OVF_STOP_EN
    logic                    w_stop;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
            r_fib   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_a     <= w_a;
            r_b     <= w_b;
            r_rem   <= w_rem;
            r_idx   <= w_idx;
            r_carry <= w_carry;
            r_a_ovf <= w_a_ovf;
            r_b_ovf <= w_b_ovf;
            r_fib   <= w_fib;
            r_ovf   <= w_ovf;
        end
    end

    // One iteration (a,b) -> (b,a+b) takes NBYTES cycles, low byte first
    always_comb begin
        w_next      = r_state;
        w_a         = r_a;
        w_b         = r_b;
        w_rem       = r_rem;
        w_idx       = r_idx;
        w_carry     = r_carry;
        w_a_ovf     = r_a_ovf;
        w_b_ovf     = r_b_ovf;
        w_fib       = r_fib;
        w_ovf       = r_ovf;
        w_last_byte = (r_idx == IDXW'(NBYTES - 1));
`ifdef FIB_OVF_STOP_EN
        w_stop      = 1'b0;
`endif
        bus.alu_op       = 2'd0;
        bus.alu_left     = 8'd0;
        bus.alu_right    = 8'd0;
        bus.alu_carry_in = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_a     = '0;
                    w_b     = W'(1);
                    w_rem   = bus.n;
                    w_idx   = '0;
                    w_carry = 1'b0;
                    w_a_ovf = 1'b0;
                    w_b_ovf = 1'b0;
                    w_next  = (bus.n != 8'd0) ? ADD : DONE;
                end
            end
            ADD: begin
                bus.alu_op       = OP_ADC;
                bus.alu_left     = r_a[r_idx];
                bus.alu_right    = r_b[r_idx];
                bus.alu_carry_in = (r_idx == '0) ? 1'b0 : r_carry;
                w_b[r_idx]       = bus.alu_result;
                w_a[r_idx]       = r_b[r_idx];
                w_carry          = bus.alu_carry_out;
                w_idx            = r_idx + 1'b1;
                if (w_last_byte) begin
                    w_idx   = '0;
                    w_rem   = r_rem - 8'd1;
                    w_a_ovf = r_b_ovf;
                    w_b_ovf = r_b_ovf | bus.alu_carry_out;
                    if (r_rem == 8'd1) begin
                        w_next = DONE;
                    end
`ifdef FIB_OVF_STOP_EN
                    // An overflowed b becomes a on the next iteration, so the result is already lost
                    else if (w_b_ovf) begin
                        w_stop = 1'b1;
                        w_next = DONE;
                    end
`endif
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase

        // Result registers load on entry to DONE so they are valid alongside done
        if (w_next == DONE && r_state != DONE) begin
            w_fib = w_a;
            w_ovf = w_a_ovf;
`ifdef FIB_OVF_STOP_EN
            if (w_stop || w_a_ovf) begin
                w_fib = '1;
                w_ovf = 1'b1;
            end
`endif
        end
    end

    assign bus.busy     = (r_state == ADD);
    assign bus.done     = (r_state == DONE);
    assign bus.fib      = r_fib;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench for fib_sequencer (NBYTES=2) with the byte ALU attached:
// stimulus pushes expected results, a negedge monitor pops and compares them on done.
module tb_fib_sequencer;
    import fib_pkg::*;

    typedef struct {
        int          n;
        logic [15:0] fib;
        logic        ovf;
        int          startCyc;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checkCount;
    int   passCount;
    int   spurious;
    exp_t expQ[$];

    fib_sequencer_if #(.NBYTES(2)) bus();

    fib_sequencer #(.NBYTES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fib_alu u_alu (
        .i_op     (bus.alu_op),
        .i_left   (bus.alu_left),
        .i_right  (bus.alu_right),
        .i_carry  (bus.alu_carry_in),
        .o_result (bus.alu_result),
        .o_carry  (bus.alu_carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (expQ.size() == 0) begin
                spurious++;
                $display("[TB] FAIL spurious done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("fib n=%0d", e.n), 64'(bus.fib), 64'(e.fib));
                checkOutput($sformatf("overflow n=%0d", e.n), 64'(bus.overflow), 64'(e.ovf));
                checkOutput($sformatf("latency n=%0d", e.n), 64'(cyc - e.startCyc), 64'(e.lat));
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, " done"}, 64'(bus.done), 64'd0);
        checkOutput({tag, " fib"}, 64'(bus.fib), 64'd0);
        checkOutput({tag, " overflow"}, 64'(bus.overflow), 64'd0);
        checkOutput({tag, " alu"}, 64'({bus.alu_left, bus.alu_right, bus.alu_carry_in, bus.alu_op}), 64'd0);
    endtask

    // Called at a negedge with the DUT idle; issues a one-cycle start
    task automatic applyStimulus(input int nVal, input logic [15:0] expFib, input logic expOvf, input int expLat);
        exp_t e;
        e.n = nVal; e.fib = expFib; e.ovf = expOvf; e.startCyc = cyc; e.lat = expLat;
        expQ.push_back(e);
        bus.start = 1'b1;
        bus.n     = 8'(nVal);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput($sformatf("busy n=%0d", nVal), 64'(bus.busy), 64'(nVal != 0));
        checkOutput($sformatf("alu_right n=%0d", nVal), 64'(bus.alu_right), 64'(nVal != 0));
        checkOutput($sformatf("alu_op/cin n=%0d", nVal), 64'({bus.alu_op, bus.alu_carry_in, bus.alu_left}), 64'd0);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) break;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
        expQ.delete();
        @(negedge clk);
    endtask

    initial begin
        cyc        = 0;
        checkCount = 0;
        passCount  = 0;
        spurious   = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.n      = 8'd0;
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(0,  16'h0000, 1'b0, 1);  waitIdle();
        applyStimulus(1,  16'h0001, 1'b0, 3);  waitIdle();
        applyStimulus(2,  16'h0001, 1'b0, 5);  waitIdle();
        applyStimulus(10, 16'h0037, 1'b0, 21); waitIdle();
        applyStimulus(13, 16'h00E9, 1'b0, 27); waitIdle();
        applyStimulus(14, 16'h0179, 1'b0, 29); waitIdle();
        applyStimulus(17, 16'h063D, 1'b0, 35); waitIdle();
        applyStimulus(24, 16'hB520, 1'b0, 49); waitIdle();
`ifdef FIB_OVF_STOP_EN
        applyStimulus(25, 16'hFFFF, 1'b1, 49); waitIdle();
`else
        applyStimulus(25, 16'h2511, 1'b1, 51); waitIdle();
`endif
        checkOutput("idle alu", 64'({bus.alu_left, bus.alu_right, bus.alu_carry_in, bus.alu_op}), 64'd0);

        // Abort: second start during ADD is ignored, reset mid-run kills the done pulse
        bus.start = 1'b1; bus.n = 8'd10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.n = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busy after ignored start", 64'(bus.busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkIdleOutputs("abort");
        repeat (30) @(negedge clk);

        reset = 1'b1; bus.start = 1'b1; bus.n = 8'd5;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        checkOutput("reset beats start", 64'(bus.busy), 64'd0);
        repeat (15) @(negedge clk);

        applyStimulus(10, 16'h0037, 1'b0, 21); waitIdle();
        checkOutput("noSpuriousDone", 64'(spurious), 64'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
